// File: rtl/pinaipple_bus_pkg.sv
// Shared types and the default device address map for the pinaipple data-bus router.
package pinaipple_bus_pkg;

  localparam int NUM_DEVICES = 5;
  localparam int MAP_ADDR_W  = 32;

  // One extra code beyond the last device marks an unmapped (error) target.
  typedef logic [$clog2(NUM_DEVICES+1)-1:0] dev_id_t;
  localparam dev_id_t ERR_ID = dev_id_t'(NUM_DEVICES);

  // Index order: RAM, GPIO, UART, Timer, SimCtrl.
  localparam logic [MAP_ADDR_W-1:0] DEV_BASE_DEFAULT [NUM_DEVICES] = '{
    32'h0010_0000, 32'h8000_0000, 32'h8000_1000, 32'h8000_2000, 32'h0002_0000
  };
  localparam logic [MAP_ADDR_W-1:0] DEV_MASK_DEFAULT [NUM_DEVICES] = '{
    32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FC00
  };

  function automatic logic addr_hit(input logic [MAP_ADDR_W-1:0] addr,
                                    input logic [MAP_ADDR_W-1:0] base,
                                    input logic [MAP_ADDR_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/pinaipple_id_fifo.sv
// Small FIFO of device IDs tracking outstanding bus requests in issue order.
module pinaipple_id_fifo
  import pinaipple_bus_pkg::*;
#(
  parameter int Depth = 2,
  parameter int CntW  = $clog2(Depth+1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  dev_id_t         data_i,
  input  logic            pop_i,
  output dev_id_t         head_o,
  output dev_id_t         tail_o,
  output logic [CntW-1:0] count_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  dev_id_t         mem_q [Depth];
  dev_id_t         tail_q;
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; the count qualifies every read.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
      tail_q          <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign tail_o  = tail_q;
  assign count_o = count_q;

endmodule

// File: rtl/pinaipple_bus_router.sv
// Single-host, N-device OBI-style data-bus router with base/mask decode and in-order responses.
// Define PINAIPPLE_ROUTER_ERRLOG_EN to add the unmapped-access log outputs err_addr_o/err_cnt_o.
module pinaipple_bus_router
  import pinaipple_bus_pkg::*;
#(
  parameter int NumDevices     = NUM_DEVICES,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int DevAddrWidth   = 20,
  parameter int MaxOutstanding = 2,
  parameter logic [AddrWidth-1:0] DevBase [NumDevices] = DEV_BASE_DEFAULT,
  parameter logic [AddrWidth-1:0] DevMask [NumDevices] = DEV_MASK_DEFAULT
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            host_req_i,
  output logic                            host_gnt_o,
  input  logic [AddrWidth-1:0]            host_addr_i,
  input  logic                            host_we_i,
  input  logic [DataWidth/8-1:0]          host_be_i,
  input  logic [DataWidth-1:0]            host_wdata_i,
  output logic                            host_rvalid_o,
  output logic [DataWidth-1:0]            host_rdata_o,
  output logic                            host_err_o,
  output logic [NumDevices-1:0]           dev_req_o,
  input  logic [NumDevices-1:0]           dev_gnt_i,
  output logic [DevAddrWidth-1:0]         dev_addr_o,
  output logic                            dev_we_o,
  output logic [DataWidth/8-1:0]          dev_be_o,
  output logic [DataWidth-1:0]            dev_wdata_o,
  input  logic [NumDevices-1:0]           dev_rvalid_i,
  input  logic [NumDevices*DataWidth-1:0] dev_rdata_i
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
  ,
  output logic [AddrWidth-1:0]            err_addr_o,
  output logic [15:0]                     err_cnt_o
`endif
);

  localparam int CntW = $clog2(MaxOutstanding+1);

  dev_id_t              sel, head, tail;
  logic [CntW-1:0]      cnt;
  logic                 ok, pop, err_armed;
  logic [NumDevices-1:0] rvalid_expect;

  assign dev_addr_o  = host_addr_i[DevAddrWidth-1:0];
  assign dev_we_o    = host_we_i;
  assign dev_be_o    = host_be_i;
  assign dev_wdata_o = host_wdata_i;

  // Descending scan so the lowest matching index has the final say.
  always_comb begin
    sel = ERR_ID;
    for (int i = NumDevices-1; i >= 0; i--) begin
      if (addr_hit(host_addr_i, DevBase[i], DevMask[i])) sel = dev_id_t'(i);
    end
  end

  always_comb begin
    host_rvalid_o = 1'b0;
    host_err_o    = 1'b0;
    host_rdata_o  = '0;
    pop           = 1'b0;
    rvalid_expect = '0;
    if (!rst_i && cnt != '0) begin
      if (head == ERR_ID) begin
        host_rvalid_o = err_armed;
        host_err_o    = err_armed;
        pop           = err_armed;
      end else begin
        for (int i = 0; i < NumDevices; i++) begin
          if (head == dev_id_t'(i)) begin
            rvalid_expect[i] = 1'b1;
            host_rvalid_o    = dev_rvalid_i[i];
            host_rdata_o     = dev_rdata_i[i*DataWidth +: DataWidth];
            pop              = dev_rvalid_i[i];
          end
        end
      end
    end
  end

  // A target switch waits for the tracker to drain; the last entry leaving this cycle counts as drained.
  always_comb begin
    ok = !rst_i && host_req_i && (int'(cnt) < MaxOutstanding) &&
         (cnt == '0 || tail == sel || (cnt == CntW'(1) && pop));
    dev_req_o  = '0;
    host_gnt_o = 1'b0;
    for (int i = 0; i < NumDevices; i++) begin
      if (sel == dev_id_t'(i)) begin
        dev_req_o[i] = ok;
        host_gnt_o   = ok && dev_gnt_i[i];
      end
    end
    if (sel == ERR_ID) host_gnt_o = ok;
  end

  pinaipple_id_fifo #(
    .Depth (MaxOutstanding),
    .CntW  (CntW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (host_gnt_o),
    .data_i  (sel),
    .pop_i   (pop),
    .head_o  (head),
    .tail_o  (tail),
    .count_o (cnt)
  );

  // Armed when the entry at head next cycle is an error entry, giving a one-cycle error response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_armed <= 1'b0;
    end else if (cnt == '0 || (cnt == CntW'(1) && pop)) begin
      err_armed <= host_gnt_o && (sel == ERR_ID);
    end else begin
      err_armed <= (head == ERR_ID);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ((dev_rvalid_i & ~rvalid_expect) == '0)
        else $warning("dev_rvalid_i %b arrived outside the tracker head", dev_rvalid_i);
    end
  end

`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else if (host_gnt_o && sel == ERR_ID) begin
      err_addr_o <= host_addr_i;
      if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pinaipple_bus_router.sv
// Directed and randomized bench for pinaipple_bus_router against a queue-level reference model.
module tb_pinaipple_bus_router;

  localparam int ND   = 5;
  localparam int MAXO = 2;
  localparam int ERR  = 5;

  localparam logic [31:0] BASE [ND] = '{32'h0010_0000, 32'h8000_0000, 32'h8000_1000,
                                        32'h8000_2000, 32'h0002_0000};
  localparam logic [31:0] MASK [ND] = '{32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000,
                                        32'hFFFF_F000, 32'hFFFF_FC00};

  logic          clk = 1'b0;
  logic          rst_i;
  logic          host_req_i, host_gnt_o, host_we_i;
  logic [31:0]   host_addr_i, host_wdata_i, host_rdata_o;
  logic [3:0]    host_be_i;
  logic          host_rvalid_o, host_err_o;
  logic [ND-1:0] dev_req_o, dev_gnt_i, dev_rvalid_i;
  logic [19:0]   dev_addr_o;
  logic          dev_we_o;
  logic [3:0]    dev_be_o;
  logic [31:0]   dev_wdata_o;
  logic [ND*32-1:0] dev_rdata_i;
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
  logic [31:0]   err_addr_o;
  logic [15:0]   err_cnt_o;
  logic [31:0]   m_err_addr;
  int            m_err_cnt;
`endif

  always #5 clk = ~clk;

  pinaipple_bus_router dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .host_req_i    (host_req_i),
    .host_gnt_o    (host_gnt_o),
    .host_addr_i   (host_addr_i),
    .host_we_i     (host_we_i),
    .host_be_i     (host_be_i),
    .host_wdata_i  (host_wdata_i),
    .host_rvalid_o (host_rvalid_o),
    .host_rdata_o  (host_rdata_o),
    .host_err_o    (host_err_o),
    .dev_req_o     (dev_req_o),
    .dev_gnt_i     (dev_gnt_i),
    .dev_addr_o    (dev_addr_o),
    .dev_we_o      (dev_we_o),
    .dev_be_o      (dev_be_o),
    .dev_wdata_o   (dev_wdata_o),
    .dev_rvalid_i  (dev_rvalid_i),
    .dev_rdata_i   (dev_rdata_i)
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
    ,
    .err_addr_o    (err_addr_o),
    .err_cnt_o     (err_cnt_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int q[$];        // outstanding target IDs in grant order
  int cur_sel;
  bit exp_gnt, exp_pop;

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < ND; i++) if ((a & MASK[i]) == BASE[i]) return i;
    return ERR;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [ND-1:0] ereq;
    logic [31:0]   erd;
    bit            erv, eerr;
    int            h;
    @(negedge clk);
    cur_sel = ref_decode(host_addr_i);
    ereq = '0; erd = '0; erv = 0; eerr = 0; exp_pop = 0; exp_gnt = 0;
    if (!rst_i) begin
      if (q.size() > 0) begin
        h = q[0];
        if (h == ERR) begin
          erv = 1; eerr = 1; exp_pop = 1;
        end else begin
          erv = dev_rvalid_i[h];
          erd = dev_rdata_i[h*32 +: 32];
          exp_pop = erv;
        end
      end
      if (host_req_i && q.size() < MAXO &&
          (q.size() == 0 || q[$] == cur_sel || (q.size() == 1 && exp_pop))) begin
        if (cur_sel == ERR) exp_gnt = 1;
        else begin
          ereq[cur_sel] = 1'b1;
          exp_gnt = dev_gnt_i[cur_sel];
        end
      end
    end
    chk("host_gnt", host_gnt_o, exp_gnt);
    chk("dev_req", dev_req_o, ereq);
    chk("host_rvalid", host_rvalid_o, erv);
    chk("host_err", host_err_o, eerr);
    chk("host_rdata", host_rdata_o, erd);
    chk("dev_addr", dev_addr_o, host_addr_i[19:0]);
    chk("dev_fwd", {dev_we_o, dev_be_o, dev_wdata_o}, {host_we_i, host_be_i, host_wdata_i});
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
    chk("err_cnt", err_cnt_o, m_err_cnt);
    chk("err_addr", err_addr_o, m_err_addr);
`endif
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_i) begin
      q.delete();
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
      m_err_cnt = 0; m_err_addr = '0;
`endif
    end else begin
      if (exp_pop) void'(q.pop_front());
      if (exp_gnt) begin
        q.push_back(cur_sel);
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
        if (cur_sel == ERR) begin
          m_err_addr = host_addr_i;
          if (m_err_cnt < 65535) m_err_cnt++;
        end
`endif
      end
    end
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int idx;
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
    m_err_cnt = 0; m_err_addr = '0;
`endif
    rst_i = 1; host_req_i = 0; host_addr_i = '0; host_we_i = 0; host_be_i = 4'hF;
    host_wdata_i = 32'h1234_5678; dev_gnt_i = '1; dev_rvalid_i = '0; dev_rdata_i = '0;
    #1;
    step(); step();
    rst_i = 0;
    step();

    // RAM read with a one-cycle response
    host_req_i = 1; host_addr_i = 32'h0010_0010;
    sample();
    chk("t1_req", dev_req_o, 5'b00001);
    chk("t1_daddr", dev_addr_o, 20'h00010);
    advance();
    host_req_i = 0; dev_rvalid_i = 5'b00001; dev_rdata_i[31:0] = 32'hDEAD_BEEF;
    sample();
    chk("t1_rdata", host_rdata_o, 32'hDEAD_BEEF);
    chk("t1_err", host_err_o, 1'b0);
    advance();
    dev_rvalid_i = '0;

    // unmapped read gets an error response
    host_req_i = 1; host_addr_i = 32'h4000_0000;
    sample();
    chk("t2_gnt", host_gnt_o, 1'b1);
    chk("t2_req", dev_req_o, 5'b00000);
    advance();
    host_req_i = 0;
    sample();
    chk("t2_rvalid", host_rvalid_o, 1'b1);
    chk("t2_err", host_err_o, 1'b1);
    chk("t2_rdata", host_rdata_o, 32'h0);
`ifdef PINAIPPLE_ROUTER_ERRLOG_EN
    chk("t2_errcnt", err_cnt_o, 16'd1);
    chk("t2_erraddr", err_addr_o, 32'h4000_0000);
`endif
    advance();

    // back-to-back RAM reads fill the tracker
    host_req_i = 1; host_addr_i = 32'h0010_0020;
    step();
    sample(); chk("t3_gnt2", host_gnt_o, 1'b1); advance();
    sample(); chk("t3_full", host_gnt_o, 1'b0); advance();
    dev_rvalid_i = 5'b00001; dev_rdata_i[31:0] = 32'hAAAA_0001;
    sample(); chk("t3_nobypass", host_gnt_o, 1'b0); chk("t3_rdA", host_rdata_o, 32'hAAAA_0001); advance();
    dev_rdata_i[31:0] = 32'hAAAA_0002;
    sample(); chk("t3_gnt3", host_gnt_o, 1'b1); chk("t3_rdB", host_rdata_o, 32'hAAAA_0002); advance();
    host_req_i = 0; dev_rvalid_i = '0;
    step();
    dev_rvalid_i = 5'b00001; dev_rdata_i[31:0] = 32'hAAAA_0003;
    sample(); chk("t3_rdC", host_rdata_o, 32'hAAAA_0003); advance();
    dev_rvalid_i = '0;

    // device switch stalls until the RAM response drains
    host_req_i = 1; host_addr_i = 32'h0010_0040;
    step();
    host_addr_i = 32'h8000_0004;
    sample(); chk("t4_stall1", host_gnt_o, 1'b0); advance();
    sample(); chk("t4_stall2", host_gnt_o, 1'b0); advance();
    dev_rvalid_i = 5'b00001; dev_rdata_i[31:0] = 32'h5555_0000;
    sample(); chk("t4_switch", host_gnt_o, 1'b1); chk("t4_req", dev_req_o, 5'b00010); advance();
    host_req_i = 0; dev_rvalid_i = 5'b00010; dev_rdata_i[63:32] = 32'h6666_0001;
    sample(); chk("t4_gpio_rd", host_rdata_o, 32'h6666_0001); advance();
    dev_rvalid_i = '0;

    // timer holds off its grant for four cycles
    dev_gnt_i = 5'b10111; host_req_i = 1; host_addr_i = 32'h8000_2008;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("t5_wait_gnt", host_gnt_o, 1'b0); chk("t5_wait_req", dev_req_o, 5'b01000); advance();
    end
    dev_gnt_i = '1;
    sample(); chk("t5_gnt", host_gnt_o, 1'b1); advance();
    host_req_i = 0; dev_rvalid_i = 5'b01000; dev_rdata_i[127:96] = 32'h7777_0003;
    step();
    dev_rvalid_i = '0;

    // reset with two outstanding, then a late RAM response
    host_req_i = 1; host_addr_i = 32'h0010_0080;
    step(); step();
    host_req_i = 0; rst_i = 1;
    step();
    rst_i = 0; dev_rvalid_i = 5'b00001;
    sample(); chk("t6_stray", host_rvalid_o, 1'b0); advance();
    dev_rvalid_i = '0; host_req_i = 1; host_addr_i = 32'h8000_0010;
    sample(); chk("t6_empty", host_gnt_o, 1'b1); advance();
    host_req_i = 0; dev_rvalid_i = 5'b00010;
    step();
    dev_rvalid_i = '0;

    // randomized traffic; devices answer only for the request at head
    for (int n = 0; n < 400; n++) begin
      idx = $urandom_range(0, 6);
      if (idx < ND) a = BASE[idx] | ($urandom & ~MASK[idx]);
      else if (idx == 5) a = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
      else a = $urandom;
      host_req_i   = ($urandom_range(0, 3) != 0);
      host_addr_i  = a;
      host_we_i    = $urandom_range(0, 1) == 1;
      host_be_i    = 4'($urandom);
      host_wdata_i = $urandom;
      dev_gnt_i    = ND'($urandom);
      for (int d = 0; d < ND; d++) dev_rdata_i[d*32 +: 32] = $urandom;
      dev_rvalid_i = '0;
      if (q.size() > 0 && q[0] != ERR && $urandom_range(0, 2) == 0) dev_rvalid_i[q[0]] = 1'b1;
      step();
    end

    host_req_i = 0;
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      dev_rvalid_i = '0;
      if (q[0] != ERR) dev_rvalid_i[q[0]] = 1'b1;
      step();
    end
    dev_rvalid_i = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pinaipple_bus_router.md
Name: pinaipple_bus_router

Overview:
- Parametrised single-host, N-device data-bus router between the core data port and peripherals.
- Replaces ad-hoc range-compare target selection and tied-off grant/response glue with:
  - base/mask address decode;
  - real gnt/rvalid handshakes;
  - in-order tracking of outstanding requests;
  - error responses for unmapped addresses.
- Sits between the core LSU port and the RAM/GPIO/UART/timer/sim-ctrl devices in the system top.

Parameters:
- NumDevices, 5, number of device ports.
- AddrWidth, 32, host address width.
- DataWidth, 32, data width (byte enables are DataWidth/8).
- DevAddrWidth, 20, device-local address width; the low bits of the host address are forwarded.
- MaxOutstanding, 2, depth of the outstanding-request tracker (≥1).
- DevBase, per-device AddrWidth array, from pinaipple_bus_pkg, device base addresses.
- DevMask, per-device AddrWidth array, from pinaipple_bus_pkg, device address masks.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- host_req_i  in  1  host request.
- host_gnt_o  out  1  request accepted this cycle.
- host_addr_i  in  AddrWidth  byte address.
- host_we_i  in  1  write enable.
- host_be_i  in  DataWidth/8  byte enables.
- host_wdata_i  in  DataWidth  write data.
- host_rvalid_o  out  1  response valid.
- host_rdata_o  out  DataWidth  read data.
- host_err_o  out  1  error response (unmapped address).
- dev_req_o  out  NumDevices  per-device request.
- dev_gnt_i  in  NumDevices  per-device grant.
- dev_addr_o  out  DevAddrWidth  local address (broadcast).
- dev_we_o  out  1  write enable (broadcast).
- dev_be_o  out  DataWidth/8  byte enables (broadcast).
- dev_wdata_o  out  DataWidth  write data (broadcast).
- dev_rvalid_i  in  NumDevices  per-device response valid.
- dev_rdata_i  in  NumDevices×DataWidth  per-device read data.

Behaviour:
- Clock and reset (already decided): one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset:
  - Tracker empties; count=0.
  - host_gnt_o=0, host_rvalid_o=0, host_err_o=0, host_rdata_o=0, dev_req_o=0.
- Decode (combinational):
  - Device i matches when (host_addr_i & DevMask[i]) == DevBase[i].
  - Lowest matching index wins.
  - No match → sel = ERR_ID (= NumDevices).
- Address forwarding: dev_addr_o = host_addr_i[DevAddrWidth-1:0]; we/be/wdata are forwarded combinationally.
- Accept condition ok:
  - host_req_i && count < MaxOutstanding;
  - and either count==0 or the tracker tail ID == sel.
  - The tail-ID rule makes a device switch stall until the tracker drains, which preserves response order.
- Device request: dev_req_o[sel] = ok, only when sel != ERR_ID; all other bits are 0.
- Grant:
  - host_gnt_o = ok && dev_gnt_i[sel] for a mapped sel.
  - For ERR_ID, host_gnt_o = ok.
- Push: on host_gnt_o, sel is written to the tracker tail. Zero added request latency (combinational path).
- Response, head = mapped device d:
  - host_rvalid_o = dev_rvalid_i[d]; host_rdata_o = dev_rdata_i[d]; host_err_o = 0.
  - Pop when dev_rvalid_i[d] is high.
- Response, head = ERR_ID:
  - host_rvalid_o=1, host_err_o=1, host_rdata_o=0.
  - Occurs one cycle after the entry reaches head; registered "err_armed" flag. Then pop.
- Push and pop in the same cycle: allowed; count is unchanged.
- A full tracker deasserts gnt; there is no bypass on a same-cycle pop.
- dev_rvalid_i from a non-head device, or with the tracker empty: ignored, and flagged by a simulation assertion.
- Reset mid-transaction: outstanding entries are discarded. Late device rvalid is ignored per the rule above.
- Writes: the device still returns rvalid, and it is forwarded to the host (OBI semantics).

Optional Feature:
- Macro: PINAIPPLE_ROUTER_ERRLOG_EN.
- Defined:
  - Adds outputs err_addr_o (AddrWidth) and err_cnt_o (16 bits).
  - err_addr_o captures the address of the most recent granted ERR_ID request.
  - err_cnt_o counts such grants and saturates at 0xFFFF.
  - Both are cleared by rst_i.
- Undefined: the ports and logic are absent. Routing behaviour is identical either way.

Decomposition:
- pinaipple_bus_pkg holds:
  - dev_id_t, sized $clog2(NumDevices+1);
  - the ERR_ID constant;
  - the default DevBase/DevMask maps: RAM 0x00100000/0xFFFF0000, GPIO 0x80000000/0xFFFFF000, UART 0x80001000/0xFFFFF000, Timer 0x80002000/0xFFFFF000, SimCtrl 0x00020000/0xFFFFFC00.
- Sub-module pinaipple_id_fifo:
  - parametrised-depth FIFO of dev_id_t;
  - exposes head and tail, count, push, pop;
  - synchronous active-high reset.

Test Plan:
- Read 0x00100010 with RAM gnt=1 and rvalid the next cycle carrying 0xDEADBEEF → dev_req_o[0] pulses, dev_addr_o=0x00010, host_rdata_o=0xDEADBEEF, host_err_o=0.
- Read 0x40000000 (unmapped) → gnt the same cycle, no dev_req_o; one cycle later rvalid=1, err=1, rdata=0. With ERRLOG_EN: err_cnt_o=1, err_addr_o=0x40000000.
- Back-to-back RAM reads with RAM rvalid delayed 3 cycles → 2 grants, 3rd request stalls (MaxOutstanding=2); responses arrive in order.
- RAM read outstanding, then a GPIO 0x80000004 request → gnt held 0 until the RAM rvalid pops; GPIO is granted in the same pop cycle.
- Timer dev_gnt_i=0 for 4 cycles → host_gnt_o=0 and dev_req_o[3]=1 held; grant on cycle 5.
- rst_i asserted with 2 outstanding, then a stray RAM rvalid → tracker count=0, host_rvalid_o stays 0.
